// File: rtl/div32_seq.sv
// Sequential restoring divider: one quotient bit per clock, signed or unsigned,
// with fixed WIDTH+1 clock latency from accepted start to the ready pulse.
module div32_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             ready,
    output logic             dbz
);

    localparam int              CW      = $clog2(WIDTH);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);
    localparam logic [CW-1:0]   LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ZERO   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_dvd;
    logic [WIDTH-1:0]   r_b;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dbz;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_nx;

    function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] v);
        return ~v + ONE;
    endfunction

    // The most negative value maps onto itself, read as an unsigned magnitude.
    function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] v, input logic s);
        return (s && v[WIDTH-1]) ? neg_f(v) : v;
    endfunction

    // One restoring step: shift in the next dividend bit and trial-subtract.
    always_comb begin
        w_rem_sh = {r_rem, r_dvd[WIDTH-1]};
        w_diff   = w_rem_sh - {1'b0, r_b};
        w_ge     = ~w_diff[WIDTH];
        w_rem_nx = w_rem_sh[WIDTH-1:0];
        if (w_ge) begin
            w_rem_nx = w_diff[WIDTH-1:0];
        end else begin
            w_rem_nx = w_rem_sh[WIDTH-1:0];
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nx = S_RUN;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_cnt == LAST) begin
                    w_state_nx = S_FIX;
                end else begin
                    w_state_nx = S_RUN;
                end
            end
            S_FIX:   w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_cnt   <= {CW{1'b0}};
            r_rem   <= ZERO;
            r_dvd   <= ZERO;
            r_b     <= ZERO;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dbz   <= 1'b0;
            q       <= ZERO;
            r       <= ZERO;
            busy    <= 1'b0;
            ready   <= 1'b0;
            dbz     <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dvd   <= mag_f(a, sign);
                        r_b     <= mag_f(b, sign);
                        r_rem   <= ZERO;
                        r_neg_q <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg_r <= sign & a[WIDTH-1];
                        r_dbz   <= (b == ZERO);
                        r_cnt   <= {CW{1'b0}};
                        busy    <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_rem <= w_rem_nx;
                    r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt + CNT_ONE;
                end
                S_FIX: begin
                    // With b==0 the remainder path already reproduces a; only q is forced.
                    q     <= r_dbz ? ONES : (r_neg_q ? neg_f(r_dvd) : r_dvd);
                    r     <= r_neg_r ? neg_f(r_rem) : r_rem;
                    dbz   <= r_dbz;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
